// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command front end.
// Contents: FSM state encoding, frame/response sizes, the highest legal
// opcode and the fixed error response word.
// Build option: SPI_CMD_PARITY_EN adds a trailing even-parity bit to the
// frame, making it 25 bits long instead of 24.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_EXEC = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

`ifdef SPI_CMD_PARITY_EN
  localparam int FRAME_BITS = 25;
`else
  localparam int FRAME_BITS = 24;
`endif
  localparam int DATA_BITS = 24;
  localparam int RESP_BITS = 16;
  localparam int CNT_W     = 5;
  localparam logic [7:0] OP_MAX = 8'd10;
  localparam logic [RESP_BITS-1:0] ERR_RESP = 16'h0080;

endpackage

// File: rtl/spi_sync.sv
// Brings the asynchronous SPI pins into the i_clk domain and produces
// single-cycle edge pulses.
// Ports:
//   i_clk, i_rst_n          system clock, async active-low reset
//   i_sclk, i_cs_n, i_mosi  raw SPI pins
//   o_sclk_rise/o_sclk_fall one-cycle SCLK edge pulses
//   o_cs_fall/o_cs_rise     one-cycle chip-select edge pulses
//   o_cs_n, o_mosi          synchronised levels, aligned with the pulses
// All outputs lag the pins by SYNC_STAGES + 1 cycles.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_cs_n,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d, mosi_out_q, mosi_out_d;
  logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
  logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
  logic sclk_s, cs_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    // Edge-detect stage: pulses and levels leave this stage together, so the
    // MOSI bit seen with a rise pulse is the one sampled at that SCLK edge.
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    mosi_out_d  = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise_d = sclk_s & ~sclk_prev_q;
    sclk_fall_d = ~sclk_s & sclk_prev_q;
    cs_fall_d   = ~cs_s & cs_prev_q;
    cs_rise_d   = cs_s & ~cs_prev_q;
  end

  // Chip select resets to the inactive (high) level so reset release does
  // not look like a CS fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      mosi_out_q  <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      mosi_out_q  <= mosi_out_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
    end
  end

  assign o_sclk_rise = sclk_rise_q;
  assign o_sclk_fall = sclk_fall_q;
  assign o_cs_fall   = cs_fall_q;
  assign o_cs_rise   = cs_rise_q;
  assign o_cs_n      = cs_prev_q;
  assign o_mosi      = mosi_out_q;

endmodule

// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave that turns 24-bit command frames {opcode byte, argA, argB}
// into operands for the execution unit, captures the result and flags, and
// returns that response on MISO during the next frame.
// Ports:
//   i_clk, i_rst_n          system clock (>= 4x SCLK), async active-low reset
//   i_sclk, i_cs_n, i_mosi  SPI inputs (MSB first)
//   o_miso                  SPI output (MSB first), 0 while CS is high
//   o_oper, o_argA, o_argB  registered opcode/operands
//   o_valid                 one-cycle strobe, result captured this cycle
//   i_result, i_OF/SF/BF/VF execution unit result and flags
//   o_perr                  one-cycle parity-error strobe
// Build option: SPI_CMD_PARITY_EN appends an even-parity bit to each frame;
// without it o_perr stays 0.
//
// state   | meaning
// IDLE    | waiting for CS fall (or a CS fall held while busy)
// RX      | shifting MOSI bits in, counting edges
// EXEC    | operands presented to the execution unit
// LOAD    | o_valid high, result/flags (or error word) captured
module spi_cmd_frontend
  import spi_cmd_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sclk,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic [N-1:0] o_oper,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic         o_valid,
  input  logic [M-1:0] i_result,
  input  logic         i_OF,
  input  logic         i_SF,
  input  logic         i_BF,
  input  logic         i_VF,
  output logic         o_perr
);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sclk     (i_sclk),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .o_sclk_rise(sclk_rise),
    .o_sclk_fall(sclk_fall),
    .o_cs_fall  (cs_fall),
    .o_cs_rise  (cs_rise),
    .o_cs_n     (cs_n_s),
    .o_mosi     (mosi_s)
  );

  state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-2:0] rx_q, rx_d;
  logic [RESP_BITS-1:0]  resp_q, resp_d, tx_q, tx_d;
  logic [N-1:0]          oper_q, oper_d;
  logic [M-1:0]          arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic valid_q, valid_d, perr_q, perr_d, err_q, err_d;
  logic par_bad_q, par_bad_d, pend_q, pend_d;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0]  data;
  logic par_bad, last_bit, start;

  always_comb begin
    rx_shift = {rx_q, mosi_s};
`ifdef SPI_CMD_PARITY_EN
    data    = rx_shift[FRAME_BITS-1:1];
    par_bad = ^rx_shift;
`else
    data    = rx_shift;
    par_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    tx_d      = tx_q;
    oper_d    = oper_q;
    arg_a_d   = arg_a_q;
    arg_b_d   = arg_b_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    err_d     = err_q;
    par_bad_d = par_bad_q;
    pend_d    = pend_q;
    start     = 1'b0;
    last_bit  = sclk_rise && (cnt_q == CNT_W'(FRAME_BITS - 1));

    // A CS fall that lands while the previous frame is still being executed
    // is remembered and serviced once the FSM is back in IDLE.
    if (cs_rise)
      pend_d = 1'b0;
    else if (cs_fall && (state_q == ST_EXEC || state_q == ST_LOAD))
      pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if ((cs_fall || pend_q) && !cs_rise) begin
          start   = 1'b1;
          state_d = ST_RX;
          rx_d    = '0;
          pend_d  = 1'b0;
        end
      end
      ST_RX: begin
        if (sclk_rise) begin
          rx_d  = rx_shift[FRAME_BITS-2:0];
          cnt_d = cnt_q + 1'b1;
        end
        if (last_bit) begin
          state_d   = ST_EXEC;
          cnt_d     = '0;
          oper_d    = data[2*M +: N];
          arg_a_d   = data[M +: M];
          arg_b_d   = data[0 +: M];
          // Opcode byte above OP_MAX covers both oper > 10 and a nonzero
          // upper nibble.
          err_d     = (data[DATA_BITS-1 -: 8] > OP_MAX) || par_bad;
          par_bad_d = par_bad;
        end else if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        state_d = ST_LOAD;
        valid_d = !err_q;
        perr_d  = par_bad_q;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        resp_d  = err_q ? ERR_RESP : {i_result, 4'b0000, i_OF, i_SF, i_BF, i_VF};
      end
      default: state_d = ST_IDLE;
    endcase

    // Transmit copy is taken at frame start so a response loaded later in
    // this frame does not disturb the bits already on the wire.
    if (cs_rise)
      tx_d = '0;
    else if (start)
      tx_d = resp_q;
    else if (sclk_fall && !cs_n_s)
      tx_d = {tx_q[RESP_BITS-2:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      resp_q    <= '0;
      tx_q      <= '0;
      oper_q    <= '0;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      err_q     <= 1'b0;
      par_bad_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      tx_q      <= tx_d;
      oper_q    <= oper_d;
      arg_a_q   <= arg_a_d;
      arg_b_q   <= arg_b_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      err_q     <= err_d;
      par_bad_q <= par_bad_d;
      pend_q    <= pend_d;
    end
  end

  assign o_miso  = tx_q[RESP_BITS-1];
  assign o_oper  = oper_q;
  assign o_argA  = arg_a_q;
  assign o_argB  = arg_b_q;
  assign o_valid = valid_q;
  // Without the parity build par_bad is constant 0, so this flop never sets.
  assign o_perr  = perr_q;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
`timescale 1ns/1ps
module tb_spi_cmd_frontend;

  localparam int HALF = 8;
  localparam int GAP  = 4;
`ifdef SPI_CMD_PARITY_EN
  localparam int FRAME_N = 25;
`else
  localparam int FRAME_N = 24;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, valid, perr;
  logic [3:0] oper;
  logic [7:0] arg_a, arg_b, result;
  logic f_of, f_sf, f_bf, f_vf;

  always #5 clk = ~clk;

  spi_cmd_frontend dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_sclk  (sclk),
    .i_cs_n  (cs_n),
    .i_mosi  (mosi),
    .o_miso  (miso),
    .o_oper  (oper),
    .o_argA  (arg_a),
    .o_argB  (arg_b),
    .o_valid (valid),
    .i_result(result),
    .i_OF    (f_of),
    .i_SF    (f_sf),
    .i_BF    (f_bf),
    .i_VF    (f_vf),
    .o_perr  (perr)
  );

  // Execution unit stub
  assign result = arg_a + arg_b + {4'b0000, oper};
  assign {f_of, f_sf, f_bf, f_vf} = {arg_a[7], arg_b[7], oper[1], oper[0]};

  int n_assert = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;
  logic [3:0] cap_oper = '0;
  logic [7:0] cap_a = '0, cap_b = '0;
  logic [15:0] prev_resp = '0;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      cap_oper  <= oper;
      cap_a     <= arg_a;
      cap_b     <= arg_b;
    end
    if (perr) perr_cnt <= perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response the front end should hold after a complete frame.
  function automatic logic [15:0] model_resp(input logic [23:0] d, input logic bad);
    logic [7:0] b0, a, b, r;
    b0 = d[23:16];
    a  = d[15:8];
    b  = d[7:0];
    if (b0 > 8'd10 || bad) return 16'h0080;
    r = a + b + b0;
    return {r, 4'h0, a[7], b[7], b0[1], b0[0]};
  endfunction

  task automatic spi_frame(input logic [23:0] data, input int nbits, input logic bad_par,
                           output logic [31:0] miso_bits);
    logic [24:0] bits;
    bits = {data, (^data) ^ bad_par};
    miso_bits = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[24-i];
      wait_clks(HALF);
      miso_bits = {miso_bits[30:0], miso};
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(GAP);
  endtask

  task automatic run_frame(input logic [23:0] data, input int nbits, input logic bad_par,
                           input string tag);
    logic [31:0] got, exp_m;
    logic full, ok;
    int v0, p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    spi_frame(data, nbits, bad_par, got);
    exp_m = {prev_resp, 16'h0000} >> (32 - nbits);
    check({tag, " miso"}, got, exp_m);
    full = (nbits == FRAME_N);
    ok = full && (data[23:16] <= 8'd10) && !bad_par;
    check({tag, " valid_count"}, 32'(valid_cnt - v0), {31'b0, ok});
    check({tag, " perr_count"}, 32'(perr_cnt - p0), {31'b0, full && bad_par});
    if (ok) begin
      check({tag, " oper"}, {28'b0, cap_oper}, {28'b0, data[19:16]});
      check({tag, " argA"}, {24'b0, cap_a}, {24'b0, data[15:8]});
      check({tag, " argB"}, {24'b0, cap_b}, {24'b0, data[7:0]});
    end
    if (full) prev_resp = model_resp(data, bad_par);
  endtask

  initial begin
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    check("reset valid", {31'b0, valid}, 0);
    check("reset miso", {31'b0, miso}, 0);

    run_frame(24'h02_10_20, FRAME_N, 1'b0, "pre_reset");

    // Reset in the middle of a frame
    cs_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst oper", {28'b0, oper}, 0);
    check("midrst argA", {24'b0, arg_a}, 0);
    check("midrst argB", {24'b0, arg_b}, 0);
    check("midrst valid", {31'b0, valid}, 0);
    check("midrst perr", {31'b0, perr}, 0);
    check("midrst miso", {31'b0, miso}, 0);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(8);
    check("idle miso", {31'b0, miso}, 0);
    prev_resp = 16'h0000;

    run_frame(24'h00_05_03, FRAME_N, 1'b0, "basic");
    run_frame(24'h01_F0_0F, 12, 1'b0, "abort12");
    run_frame(24'h01_F0_0F, FRAME_N, 1'b0, "after_abort");
    run_frame(24'h0C_11_22, FRAME_N, 1'b0, "illegal_op");
    run_frame(24'h0A_7F_01, FRAME_N, 1'b0, "op_max");
    run_frame(24'h32_01_02, FRAME_N, 1'b0, "illegal_hi");
    run_frame(24'h0B_00_00, FRAME_N, 1'b0, "op_11");

    // Back-to-back frames, GAP idle cycles between CS rise and fall
    for (int k = 0; k < 3; k++)
      run_frame({4'h0, 4'($urandom_range(0, 10)), 16'($urandom)}, FRAME_N, 1'b0, "b2b");

`ifdef SPI_CMD_PARITY_EN
    run_frame(24'h00_01_01, FRAME_N, 1'b1, "parity_bad");
    run_frame(24'h03_44_55, FRAME_N, 1'b0, "parity_ok");
`endif

    for (int k = 0; k < 16; k++) begin
      logic [23:0] d;
      int nb;
      logic bp;
      d[23:16] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(11, 255))
                                             : 8'($urandom_range(0, 10));
      d[15:0] = 16'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FRAME_N - 1)) : FRAME_N;
      bp = 1'b0;
`ifdef SPI_CMD_PARITY_EN
      bp = ($urandom_range(0, 5) == 0);
`endif
      run_frame(d, nb, bp, "rand");
    end

    run_frame(24'h00_00_00, FRAME_N, 1'b0, "flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
